// File: rtl/fetch_queue_mw.sv
// Multi-lane first-word-fall-through fetch queue. It takes up to LANES entries
// per cycle and presents up to LANES of the oldest entries to decode.
module fetch_queue_mw #(
   parameter int unsigned WIDTH        = 64,
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned LANES        = 2,
   parameter int unsigned AFULL_THRESH = 6
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic [LANES-1:0]            enq_valid,
   input  logic [LANES*WIDTH-1:0]      enq_data,
   output logic                        enq_ready,
   output logic [LANES-1:0]            deq_valid,
   output logic [LANES*WIDTH-1:0]      deq_data,
   input  logic [LANES-1:0]            deq_ready,
   output logic [$clog2(DEPTH+1)-1:0]  count,
   output logic                        empty,
   output logic                        full,
   output logic                        almost_full
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [CW-1:0]    r_count;

   logic [LANES-1:0] w_enq_acc;
   logic [CW-1:0]    w_n_enq;
   logic [CW-1:0]    w_n_deq;
   logic             w_run_e;
   logic             w_run_d;
   logic             w_enq_contig;

   // Status is decoded from the registered count only, so a same-cycle pop
   // never feeds back into enq_ready.
   assign enq_ready   = (CW'(DEPTH) - r_count) >= CW'(LANES);
   assign count       = r_count;
   assign empty       = (r_count == '0);
   assign full        = (r_count == CW'(DEPTH));
   assign almost_full = (r_count >= CW'(AFULL_THRESH));

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign deq_valid[g] = r_count > CW'(g);
      assign deq_data[g*WIDTH +: WIDTH] =
         deq_valid[g] ? r_mem[r_head + PW'(g)] : '0;
   end

   // Lanes count only while every lower lane also fires.
   always_comb begin
      w_enq_acc = '0;
      w_n_enq   = '0;
      w_n_deq   = '0;
      w_run_e   = enq_ready;
      w_run_d   = 1'b1;
      for (int i = 0; i < LANES; i++) begin
         w_run_e      = w_run_e & enq_valid[i];
         w_enq_acc[i] = w_run_e;
         w_n_enq      = w_n_enq + CW'(w_run_e);
         w_run_d      = w_run_d & deq_valid[i] & deq_ready[i];
         w_n_deq      = w_n_deq + CW'(w_run_d);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + PW'(w_n_deq);
         r_tail  <= r_tail + PW'(w_n_enq);
         r_count <= r_count + w_n_enq - w_n_deq;
      end
   end

   // Storage is intentionally left out of reset.
   always_ff @(posedge clk) begin
      if (!flush) begin
         for (int i = 0; i < LANES; i++) begin
            if (w_enq_acc[i]) begin
               r_mem[r_tail + PW'(i)] <= enq_data[i*WIDTH +: WIDTH];
            end
         end
      end
   end

   // Valid lanes must form a contiguous run starting at lane 0.
   assign w_enq_contig = (enq_valid & (enq_valid + LANES'(1))) == '0;

   a_enq_contig: assert property (@(posedge clk) disable iff (!rst) w_enq_contig);

endmodule

// File: tb/tb_fetch_queue_mw.sv
// Bench for fetch_queue_mw: table-driven fill/drain, directed corner sequences,
// then random traffic checked against a queue-based reference model.
module tb_fetch_queue_mw;

   localparam int unsigned W  = 64;
   localparam int unsigned D  = 8;
   localparam int unsigned L  = 2;
   localparam int unsigned AF = 6;

   logic           clk = 1'b0;
   logic           rst;
   logic           flush;
   logic [1:0]     enq_valid;
   logic [127:0]   enq_data;
   logic           enq_ready;
   logic [1:0]     deq_valid;
   logic [127:0]   deq_data;
   logic [1:0]     deq_ready;
   logic [3:0]     count;
   logic           empty;
   logic           full;
   logic           almost_full;

   int checks = 0;
   int errors = 0;
   logic [63:0] q[$];

   fetch_queue_mw #(.WIDTH(W), .DEPTH(D), .LANES(L), .AFULL_THRESH(AF)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
      .deq_valid(deq_valid), .deq_data(deq_data), .deq_ready(deq_ready),
      .count(count), .empty(empty), .full(full), .almost_full(almost_full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  ev;
      logic [63:0] d0;
      logic [63:0] d1;
      logic [1:0]  dr;
      logic [3:0]  cnt;
      logic [1:0]  dv;
      logic [63:0] q0;
      logic [63:0] q1;
      logic        er;
      logic        em;
      logic        af;
      logic        fu;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected outputs straight from the queue contents.
   task automatic chk_model(input string tag);
      int n;
      n = q.size();
      chk({tag, ".count"}, 64'(count), 64'(n));
      chk({tag, ".empty"}, 64'(empty), 64'(n == 0));
      chk({tag, ".full"}, 64'(full), 64'(n == D));
      chk({tag, ".afull"}, 64'(almost_full), 64'(n >= AF));
      chk({tag, ".enq_ready"}, 64'(enq_ready), 64'((D - n) >= L));
      chk({tag, ".deq_valid"}, 64'(deq_valid), 64'({n > 1, n > 0}));
      chk({tag, ".lane0"}, deq_data[63:0], (n > 0) ? q[0] : 64'h0);
      chk({tag, ".lane1"}, deq_data[127:64], (n > 1) ? q[1] : 64'h0);
   endtask

   task automatic apply(input logic [1:0] ev, input logic [63:0] d0, input logic [63:0] d1,
                        input logic [1:0] dr, input logic fl);
      enq_valid = ev;
      enq_data  = {d1, d0};
      deq_ready = dr;
      flush     = fl;
      #1;
   endtask

   // Clock once and move the model by the rules: pops from the front,
   // all-or-nothing enqueue credit from the pre-edge occupancy, flush wins.
   task automatic advance();
      int n, nd, ne;
      logic [63:0] d0, d1;
      n  = q.size();
      nd = 0;
      ne = 0;
      if (n > 0 && deq_ready[0]) nd = (n > 1 && deq_ready[1]) ? 2 : 1;
      if ((D - n) >= L && enq_valid[0]) ne = enq_valid[1] ? 2 : 1;
      d0 = enq_data[63:0];
      d1 = enq_data[127:64];
      @(posedge clk);
      if (flush) q.delete();
      else begin
         repeat (nd) void'(q.pop_front());
         if (ne > 0) q.push_back(d0);
         if (ne > 1) q.push_back(d1);
      end
      #1;
      enq_valid = 2'b00;
      deq_ready = 2'b00;
      flush     = 1'b0;
   endtask

   task automatic step(input logic [1:0] ev, input logic [63:0] d0, input logic [63:0] d1,
                       input logic [1:0] dr, input logic fl, input string tag);
      apply(ev, d0, d1, dr, fl);
      chk_model(tag);
      advance();
   endtask

   initial begin
      //         ev     d0     d1     dr     cnt dv     q0     q1     er    em    af    fu
      tbl[0] = '{2'b11, 64'h10, 64'h11, 2'b00, 0, 2'b00, 64'h0,  64'h0,  1'b1, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{2'b11, 64'h12, 64'h13, 2'b00, 2, 2'b11, 64'h10, 64'h11, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{2'b11, 64'h14, 64'h15, 2'b00, 4, 2'b11, 64'h10, 64'h11, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{2'b11, 64'h16, 64'h17, 2'b00, 6, 2'b11, 64'h10, 64'h11, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[4] = '{2'b11, 64'h99, 64'h98, 2'b00, 8, 2'b11, 64'h10, 64'h11, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[5] = '{2'b00, 64'h0,  64'h0,  2'b11, 8, 2'b11, 64'h10, 64'h11, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[6] = '{2'b00, 64'h0,  64'h0,  2'b11, 6, 2'b11, 64'h12, 64'h13, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[7] = '{2'b00, 64'h0,  64'h0,  2'b11, 4, 2'b11, 64'h14, 64'h15, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{2'b00, 64'h0,  64'h0,  2'b11, 2, 2'b11, 64'h16, 64'h17, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[9] = '{2'b00, 64'h0,  64'h0,  2'b00, 0, 2'b00, 64'h0,  64'h0,  1'b1, 1'b1, 1'b0, 1'b0};

      rst       = 1'b0;
      flush     = 1'b0;
      enq_valid = 2'b00;
      enq_data  = '0;
      deq_ready = 2'b00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      apply(2'b00, 0, 0, 2'b00, 1'b0);
      chk_model("post_reset");
      advance();

      // Asynchronous reset with five entries held
      step(2'b11, 64'h1, 64'h2, 2'b00, 1'b0, "ar.fill0");
      step(2'b11, 64'h3, 64'h4, 2'b00, 1'b0, "ar.fill1");
      step(2'b01, 64'h5, 64'h6, 2'b00, 1'b0, "ar.fill2");
      chk("ar.count5", 64'(count), 64'd5);
      #2 rst = 1'b0;
      #1;
      chk("ar.count", 64'(count), 64'd0);
      chk("ar.deq_valid", 64'(deq_valid), 64'd0);
      chk("ar.empty", 64'(empty), 64'd1);
      chk("ar.enq_ready", 64'(enq_ready), 64'd1);
      chk("ar.deq_data_lo", deq_data[63:0], 64'h0);
      chk("ar.deq_data_hi", deq_data[127:64], 64'h0);
      q.delete();
      @(posedge clk);
      #1 rst = 1'b1;

      // Fill to full and drain in order
      for (int i = 0; i < 10; i++) begin
         apply(tbl[i].ev, tbl[i].d0, tbl[i].d1, tbl[i].dr, 1'b0);
         chk($sformatf("tbl%0d.count", i), 64'(count), 64'(tbl[i].cnt));
         chk($sformatf("tbl%0d.deq_valid", i), 64'(deq_valid), 64'(tbl[i].dv));
         chk($sformatf("tbl%0d.lane0", i), deq_data[63:0], tbl[i].q0);
         chk($sformatf("tbl%0d.lane1", i), deq_data[127:64], tbl[i].q1);
         chk($sformatf("tbl%0d.enq_ready", i), 64'(enq_ready), 64'(tbl[i].er));
         chk($sformatf("tbl%0d.empty", i), 64'(empty), 64'(tbl[i].em));
         chk($sformatf("tbl%0d.afull", i), 64'(almost_full), 64'(tbl[i].af));
         chk($sformatf("tbl%0d.full", i), 64'(full), 64'(tbl[i].fu));
         advance();
      end

      // Odd occupancy, simultaneous traffic, pointer wrap
      step(2'b11, 64'h40, 64'h41, 2'b00, 1'b0, "wr.f0");
      step(2'b11, 64'h42, 64'h43, 2'b00, 1'b0, "wr.f1");
      step(2'b11, 64'h44, 64'h45, 2'b00, 1'b0, "wr.f2");
      step(2'b01, 64'h46, 64'h0,  2'b00, 1'b0, "wr.f3");
      chk("wr.count7", 64'(count), 64'd7);
      chk("wr.enq_ready7", 64'(enq_ready), 64'd0);
      step(2'b11, 64'h5A, 64'h5B, 2'b11, 1'b0, "wr.pop2");
      chk("wr.count5", 64'(count), 64'd5);
      step(2'b11, 64'h47, 64'h48, 2'b01, 1'b0, "wr.mix");
      chk("wr.count6", 64'(count), 64'd6);
      chk("wr.head", deq_data[63:0], 64'h43);
      for (int i = 0; i < 4; i++) step(2'b00, 0, 0, 2'b11, 1'b0, $sformatf("wr.drain%0d", i));

      // Partial lanes
      step(2'b01, 64'hA, 64'hBAD, 2'b00, 1'b0, "pl.enq1");
      chk("pl.deq_valid", 64'(deq_valid), 64'd1);
      chk("pl.lane1_zero", deq_data[127:64], 64'h0);
      step(2'b00, 0, 0, 2'b10, 1'b0, "pl.dr10");
      chk("pl.count_hold", 64'(count), 64'd1);
      step(2'b00, 0, 0, 2'b01, 1'b0, "pl.pop");

      // Flush with same-cycle enqueue and dequeue
      step(2'b11, 64'h61, 64'h62, 2'b00, 1'b0, "fl.f0");
      step(2'b11, 64'h63, 64'h64, 2'b00, 1'b0, "fl.f1");
      step(2'b01, 64'h65, 64'h0,  2'b00, 1'b0, "fl.f2");
      step(2'b11, 64'h77, 64'h78, 2'b01, 1'b1, "fl.flush");
      chk("fl.count", 64'(count), 64'd0);
      chk("fl.empty", 64'(empty), 64'd1);
      step(2'b11, 64'h20, 64'h21, 2'b00, 1'b0, "fl.enq");
      chk("fl.lane0", deq_data[63:0], 64'h20);
      chk("fl.lane1", deq_data[127:64], 64'h21);
      step(2'b00, 0, 0, 2'b11, 1'b0, "fl.drain");

      // Random traffic against the model
      for (int i = 0; i < 2000; i++) begin
         logic [1:0] ev;
         case ($urandom_range(0, 2))
            0:       ev = 2'b00;
            1:       ev = 2'b01;
            default: ev = 2'b11;
         endcase
         step(ev, {$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom_range(0, 3)),
              ($urandom_range(0, 31) == 0), "rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
